// File: rtl/cfu_simd_mac.sv
// Multi-cycle packed-SIMD signed MAC CFU with input offset and shift-and-clamp requantize.
// Define CFU_SIMD_MAC_SATURATE_EN for a saturating accumulate with a sticky overflow flag.
module cfu_simd_mac #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LANES     = 4,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int          CLAMP_MIN = 2,
    parameter int          CLAMP_MAX = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_payload_function_id,
    input  logic [DATA_W-1:0] cmd_payload_inputs_0,
    input  logic [DATA_W-1:0] cmd_payload_inputs_1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_payload_outputs_0
);

    localparam int unsigned CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PROD_W = 2 * LANE_W + 2;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                    r_state, w_state_d;
    logic [DATA_W-1:0]         r_a, r_b, r_rsp;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [LANE_W:0]    r_ofs;
    logic [CNT_W-1:0]          r_lane;

    logic [2:0]                w_fid;
    logic                      w_accept, w_last;
    logic signed [LANE_W-1:0]  w_a_lane, w_b_lane;
    logic signed [LANE_W+1:0]  w_sum;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext, w_acc_mac, w_t, w_q;
    logic signed [DATA_W-1:0]  w_acc_ext;
    logic [DATA_W-1:0]         w_result;
    logic                      w_unused;

    assign w_fid     = cmd_payload_function_id[2:0];
    assign w_unused  = ^cmd_payload_function_id[9:3];
    assign cmd_ready = (r_state == StIdle);
    assign rsp_valid = (r_state == StResp);
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_last    = (r_lane == CNT_W'(LANES - 1));
    assign rsp_payload_outputs_0 = r_rsp;

    // Operands shift down one lane per BUSY cycle, so the active lane is always at the LSBs.
    assign w_a_lane   = r_a[LANE_W-1:0];
    assign w_b_lane   = r_b[LANE_W-1:0];
    assign w_sum      = (LANE_W+2)'(w_a_lane) + (LANE_W+2)'(r_ofs);
    assign w_prod     = PROD_W'(w_sum) * PROD_W'(w_b_lane);
    assign w_prod_ext = ACC_W'(w_prod);

`ifdef CFU_SIMD_MAC_SATURATE_EN
    logic                    r_sat;
    logic signed [ACC_W:0]   w_wide;
    logic                    w_ovf;

    assign w_wide    = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod_ext);
    assign w_ovf     = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    assign w_acc_mac = !w_ovf ? w_wide[ACC_W-1:0] :
                       w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign w_acc_mac = r_acc + w_prod_ext;
`endif

    assign w_acc_ext = DATA_W'(r_acc);
    assign w_t       = r_acc >>> cmd_payload_inputs_1[4:0];

    always_comb begin
        w_q = w_t;
        if (w_t < ACC_W'(CLAMP_MIN)) begin
            w_q = ACC_W'(CLAMP_MIN);
        end else if (w_t > ACC_W'(CLAMP_MAX)) begin
            w_q = ACC_W'(CLAMP_MAX);
        end
    end

    always_comb begin
        w_result = '1;
        case (w_fid)
            3'd0: w_result = w_acc_ext;
            3'd1: w_result = '0;
            3'd2: begin
                w_result = w_acc_ext;
`ifdef CFU_SIMD_MAC_SATURATE_EN
                if (ACC_W < DATA_W) begin
                    w_result[DATA_W-1] = r_sat;
                end
`endif
            end
            3'd3: w_result = '0;
            3'd4: w_result = DATA_W'(w_q);
            default: w_result = '1;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_d = (w_fid == 3'd1) ? StBusy : StResp;
            StBusy: if (w_last) w_state_d = StResp;
            StResp: if (rsp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_rsp  <= '0;
            r_acc  <= '0;
            r_ofs  <= '0;
            r_lane <= '0;
`ifdef CFU_SIMD_MAC_SATURATE_EN
            r_sat  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a    <= cmd_payload_inputs_0;
            r_b    <= cmd_payload_inputs_1;
            r_lane <= '0;
            if (w_fid != 3'd1) begin
                r_rsp <= w_result;
            end
            if (w_fid == 3'd0) begin
                r_acc <= '0;
`ifdef CFU_SIMD_MAC_SATURATE_EN
                r_sat <= 1'b0;
`endif
            end
            if (w_fid == 3'd3) begin
                r_ofs <= cmd_payload_inputs_0[LANE_W:0];
            end
        end else if (r_state == StBusy) begin
            r_acc  <= w_acc_mac;
            r_a    <= r_a >> LANE_W;
            r_b    <= r_b >> LANE_W;
            r_lane <= r_lane + CNT_W'(1);
`ifdef CFU_SIMD_MAC_SATURATE_EN
            r_sat  <= r_sat | w_ovf;
`endif
            if (w_last) begin
                r_rsp <= DATA_W'(w_acc_mac);
            end
        end
    end

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Directed and randomized checks of cfu_simd_mac against an arithmetic reference model.
module tb_cfu_simd_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint m_acc = 0;
    longint m_ofs = 0;
    bit     m_sat = 1'b0;

    cfu_simd_mac dut (
        .clk                    (clk),
        .reset                  (reset),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0   (cmd_payload_inputs_0),
        .cmd_payload_inputs_1   (cmd_payload_inputs_1),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_payload_outputs_0  (rsp_payload_outputs_0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint acc_add(input longint acc, input longint p);
        longint s;
        s = acc + p;
`ifdef CFU_SIMD_MAC_SATURATE_EN
        if (s > 64'sd2147483647) begin
            s = 64'sd2147483647;
            m_sat = 1'b1;
        end else if (s < -64'sd2147483648) begin
            s = -64'sd2147483648;
            m_sat = 1'b1;
        end
        return s;
`else
        return longint'(int'(s));
`endif
    endfunction

    function automatic logic [31:0] model_exec(input logic [2:0] fid, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] r;
        longint      t, av, bv;
        r = 32'hFFFF_FFFF;
        case (fid)
            3'd0: begin
                r = m_acc[31:0];
                m_acc = 0;
                m_sat = 1'b0;
            end
            3'd1: begin
                for (int i = 0; i < 4; i++) begin
                    av = longint'($signed(a[8*i +: 8]));
                    bv = longint'($signed(b[8*i +: 8]));
                    m_acc = acc_add(m_acc, (av + m_ofs) * bv);
                end
                r = m_acc[31:0];
            end
            3'd2: r = m_acc[31:0];
            3'd3: begin
                m_ofs = longint'(a[8:0]);
                if (m_ofs >= 256) m_ofs -= 512;
                r = 32'h0;
            end
            3'd4: begin
                t = m_acc >>> int'(b[4:0]);
                if (t < 2) t = 2;
                if (t > 31) t = 31;
                r = t[31:0];
            end
            default: r = 32'hFFFF_FFFF;
        endcase
        return r;
    endfunction

    // Entered and left on a falling edge; keep leaves cmd_valid high for back-to-back issue.
    task automatic issue(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit keep, input bit noise,
                         output logic [31:0] res);
        logic [31:0] exp;
        int          w, n;
        bit          got;
        exp = model_exec(fid[2:0], a, b);
        cmd_payload_function_id = fid;
        cmd_payload_inputs_0    = a;
        cmd_payload_inputs_1    = b;
        cmd_valid               = 1'b1;
        rsp_ready               = (hold == 0);
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            got = rsp_valid;
            if (!keep) begin
                cmd_valid = noise && (n < 3);
                if (noise) cmd_payload_function_id = 10'd0;
            end
        end
        check("latency", 32'(n), (fid[2:0] == 3'd1) ? 32'd5 : 32'd1);
        res = rsp_payload_outputs_0;
        check("result", res, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_payload", rsp_payload_outputs_0, exp);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("retired_valid", 32'(rsp_valid), 32'd0);
        check("retired_idle", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] res;
        logic [9:0]  rf;
        logic [31:0] ra, rb;

        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_payload_function_id = '0;
        cmd_payload_inputs_0 = '0;
        cmd_payload_inputs_1 = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_payload", rsp_payload_outputs_0, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        issue(10'd3, 32'h0, 32'h0, 0, 0, 0, res);
        issue(10'd1, 32'h0102_0304, 32'h0101_0101, 0, 0, 0, res);
        check("tp_mac_10", res, 32'd10);
        issue(10'd2, 32'h0, 32'h0, 0, 0, 0, res);
        check("tp_accrd_10", res, 32'd10);

        issue(10'd3, 32'h080, 32'h0, 0, 0, 0, res);
        issue(10'd1, 32'h8080_8080, 32'h0202_0202, 0, 0, 0, res);
        issue(10'd2, 32'h0, 32'h0, 0, 0, 0, res);
        check("tp_offset_cancel", res, 32'd10);

        issue(10'd0, 32'h0, 32'h0, 0, 0, 0, res);
        issue(10'd3, 32'h0, 32'h0, 0, 0, 0, res);
        issue(10'd1, 32'h7D7D_7D7D, 32'h0202_0202, 0, 0, 0, res);
        check("tp_preload_1000", res, 32'd1000);
        issue(10'd4, 32'h0, 32'd5, 0, 0, 0, res);
        check("tp_requant_31", res, 32'd31);
        issue(10'd0, 32'h0, 32'h0, 0, 0, 0, res);
        check("tp_clr_1000", res, 32'd1000);
        issue(10'd4, 32'h0, 32'd0, 0, 0, 0, res);
        check("tp_requant_min", res, 32'd2);

        issue(10'd1, 32'hFFFF_FFFF, 32'h0101_0101, 0, 0, 0, res);
        check("tp_neg_acc", res, 32'hFFFF_FFFC);
        issue(10'd4, 32'h0, 32'd31, 0, 0, 0, res);
        check("tp_shift31", res, 32'd2);

        issue(10'd1, $urandom, $urandom, 10, 0, 0, res);
        issue(10'd1, $urandom, $urandom, 0, 0, 1, res);
        issue(10'd2, 32'h0, 32'h0, 0, 0, 0, res);

        // Reset while the datapath is on lane 2 discards the pending MAC.
        cmd_payload_function_id = 10'd1;
        cmd_payload_inputs_0 = 32'h1111_1111;
        cmd_payload_inputs_1 = 32'h2222_2222;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midbusy_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midbusy_idle", 32'(cmd_ready), 32'd1);
        check("midbusy_payload", rsp_payload_outputs_0, 32'd0);
        m_acc = 0;
        m_ofs = 0;
        m_sat = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(10'd2, 32'h0, 32'h0, 0, 0, 0, res);
        check("midbusy_acc_zero", res, 32'd0);

        issue(10'b1010101_111, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, res);
        check("tp_op7", res, 32'hFFFF_FFFF);

        for (int k = 0; k < 20; k++) begin
            rf = 10'($urandom);
            ra = $urandom;
            rb = $urandom;
            issue(rf, ra, rb, 0, 1, 0, res);
        end
        cmd_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rf = 10'($urandom);
            ra = $urandom;
            rb = $urandom;
            issue(rf, ra, rb, int'($urandom_range(0, 2)), 0, 0, res);
        end
        issue(10'd2, 32'h0, 32'h0, 0, 0, 0, res);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
